// File: rtl/uart_tx.sv
// UART transmitter: AXI4-Stream byte in, 8N1 frame out on Tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.
module uart_tx #(
  parameter int CYCLES_PER_BIT = 16
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] S_axis_tdata,
  input  logic       S_axis_tvalid,
  output logic       S_axis_tready,
  output logic       Tx,
  output logic       Busy
);

  // state         | meaning
  // ST_IDLE       | line high, ready for a byte
  // ST_START_BIT  | driving start bit (0)
  // ST_DATA_BIT   | driving data bits, LSB first
  // ST_PARITY_BIT | driving even parity (UART_TX_PARITY_EN only)
  // ST_STOP_BIT   | driving stop bit (1)

  localparam int CNT_W = $clog2(CYCLES_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_BIT,
    ST_DATA_BIT,
`ifdef UART_TX_PARITY_EN
    ST_PARITY_BIT,
`endif
    ST_STOP_BIT
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cycle_counter;
  logic [2:0]       bit_counter;
  logic [7:0]       shift_reg;
  logic             tx_next, tready_next, busy_next;
  logic             handshake, bit_end, last_data_bit;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  assign handshake     = (state == ST_IDLE) && S_axis_tvalid && S_axis_tready;
  assign bit_end       = (cycle_counter == CNT_MAX);
  assign last_data_bit = (bit_counter == 3'd7);

  // State and registered outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state         <= ST_IDLE;
      Tx            <= 1'b1;
      S_axis_tready <= 1'b0;
      Busy          <= 1'b0;
    end else begin
      state         <= state_next;
      Tx            <= tx_next;
      S_axis_tready <= tready_next;
      Busy          <= busy_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (handshake) state_next = ST_START_BIT;
      ST_START_BIT: if (bit_end) state_next = ST_DATA_BIT;
      ST_DATA_BIT: begin
        if (bit_end && last_data_bit) begin
`ifdef UART_TX_PARITY_EN
          state_next = ST_PARITY_BIT;
`else
          state_next = ST_STOP_BIT;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY_BIT: if (bit_end) state_next = ST_STOP_BIT;
`endif
      ST_STOP_BIT:  if (bit_end) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; Tx switches on the last cycle of each bit.
  always_comb begin
    tx_next     = Tx;
    tready_next = S_axis_tready;
    busy_next   = Busy;
    case (state)
      ST_IDLE: begin
        tx_next     = !handshake;
        tready_next = !handshake;
        busy_next   = handshake;
      end
      ST_START_BIT: if (bit_end) tx_next = shift_reg[0];
      ST_DATA_BIT: begin
        if (bit_end) begin
          if (last_data_bit) begin
`ifdef UART_TX_PARITY_EN
            tx_next = parity_bit;
`else
            tx_next = 1'b1;
`endif
          end else begin
            tx_next = shift_reg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY_BIT: if (bit_end) tx_next = 1'b1;
`endif
      ST_STOP_BIT: begin
        if (bit_end) begin
          tready_next = 1'b1;
          busy_next   = 1'b0;
        end
      end
      default: begin
        tx_next     = 1'b1;
        tready_next = 1'b0;
        busy_next   = 1'b0;
      end
    endcase
  end

  // Bit timing and data path.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cycle_counter <= '0;
      bit_counter   <= '0;
      shift_reg     <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit    <= 1'b0;
`endif
    end else if (state == ST_IDLE) begin
      cycle_counter <= '0;
      bit_counter   <= '0;
      if (handshake) begin
        shift_reg <= S_axis_tdata;
`ifdef UART_TX_PARITY_EN
        parity_bit <= ^S_axis_tdata;
`endif
      end
    end else begin
      cycle_counter <= bit_end ? '0 : cycle_counter + 1'b1;
      if (state == ST_DATA_BIT && bit_end) begin
        shift_reg   <= {1'b0, shift_reg[7:1]};
        bit_counter <= bit_counter + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at 16 cycles per bit.
module tb_uart_tx;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic       Clk;
  logic       Rst_n;
  logic [7:0] S_axis_tdata;
  logic       S_axis_tvalid;
  logic       S_axis_tready;
  logic       Tx;
  logic       Busy;

  int tests = 0;
  int fails = 0;

  uart_tx #(.CYCLES_PER_BIT(CPB)) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .S_axis_tdata(S_axis_tdata),
    .S_axis_tvalid(S_axis_tvalid),
    .S_axis_tready(S_axis_tready),
    .Tx(Tx),
    .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  // Called at the negedge right after the handshake edge; returns at the first idle cycle.
  // At cycle 40 (inside data bit 1) tdata/tvalid are rewritten to exercise the busy-time ignore.
  task automatic check_frame(input logic [7:0] d, input logic [7:0] alt_data, input logic alt_valid);
    logic [10:0] fr;
`ifdef UART_TX_PARITY_EN
    fr = {1'b1, ^d, d, 1'b0};
`else
    fr = {1'b0, 1'b1, d, 1'b0};
`endif
    for (int k = 0; k < FRAME_CYC; k++) begin
      if (k == 40) begin
        S_axis_tdata  = alt_data;
        S_axis_tvalid = alt_valid;
      end
      check($sformatf("tx d=%0h k=%0d", d, k), Tx, fr[k / CPB]);
      check($sformatf("busy d=%0h k=%0d", d, k), Busy, 1'b1);
      if (k == 0) check("tready low in frame", S_axis_tready, 1'b0);
      tick();
    end
    check("busy end", Busy, 1'b0);
    check("tready end", S_axis_tready, 1'b1);
    check("tx idle", Tx, 1'b1);
  endtask

  initial begin
    // Reset with tvalid already asserted.
    Rst_n         = 1'b0;
    S_axis_tvalid = 1'b1;
    S_axis_tdata  = 8'h55;
    repeat (3) tick();
    check("rst tx", Tx, 1'b1);
    check("rst tready", S_axis_tready, 1'b0);
    check("rst busy", Busy, 1'b0);
    Rst_n = 1'b1;
    tick();
    check("tready after release", S_axis_tready, 1'b1);
    check("no accept at release", Busy, 1'b0);

    // 0x55 frame.
    tick();
    S_axis_tvalid = 1'b0;
    check_frame(8'h55, 8'h00, 1'b0);
    tick();
    check("idle stays idle", Busy, 1'b0);

    // Back-to-back 0xA3 then 0x0F with tvalid held; second handshake 161 cycles after the first.
    S_axis_tvalid = 1'b1;
    S_axis_tdata  = 8'hA3;
    tick();
    check_frame(8'hA3, 8'h0F, 1'b1);
    tick();
    check("b2b second accepted", Busy, 1'b1);
    check("b2b start bit", Tx, 1'b0);
    check_frame(8'h0F, 8'h0F, 1'b0);
    tick();
    check("no third frame", Busy, 1'b0);

    // 0x00 with tdata changed to 0xFF mid-frame.
    S_axis_tvalid = 1'b1;
    S_axis_tdata  = 8'h00;
    tick();
    check_frame(8'h00, 8'hFF, 1'b0);

    // Reset pulse during data bit 3 of a 0x00 frame.
    S_axis_tvalid = 1'b1;
    S_axis_tdata  = 8'h00;
    tick();
    S_axis_tvalid = 1'b0;
    repeat (70) tick();
    check("bit3 low before reset", Tx, 1'b0);
    Rst_n = 1'b0;
    #1;
    check("async rst tx", Tx, 1'b1);
    check("async rst busy", Busy, 1'b0);
    check("async rst tready", S_axis_tready, 1'b0);
    S_axis_tvalid = 1'b1;
    S_axis_tdata  = 8'hC4;
    tick();
    tick();
    check("held in reset", Busy, 1'b0);
    Rst_n = 1'b1;
    tick();
    check("post-rst tready", S_axis_tready, 1'b1);
    check("post-rst not busy", Busy, 1'b0);
    tick();
    S_axis_tvalid = 1'b0;
    check_frame(8'hC4, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
